// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer: fetches into the IR, walks the decoder bank's
// execute states via next_state, stalls data-memory words on dmem_ready.
module cpu_control_sequencer #(
  parameter logic [5:0] HALT_OP = 6'h3F,
  parameter int         CW_W    = 33
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     imem_data,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [31:0]     ir,
  output logic [1:0]      state,
  input  logic [CW_W-1:0] cw_in,
  input  logic            dmem_ready,
  output logic [CW_W-1:0] cw_out,
  input  logic [4:0]      status_in,
  output logic [4:0]      status,
  output logic            halted,
  output logic [15:0]     retired
);

  localparam int RF_W_BIT      = 9;
  localparam int RAM_EN_BIT    = 8;
  localparam int RAM_W_BIT     = 7;
  localparam int PC_EN_BIT     = 6;
  localparam int STATUS_LD_BIT = 2;

  // alu_bs=1, alu_fs=11111, rf_sa/sb/da=31, everything else 0
  localparam logic [CW_W-1:0] NOP_CW =
    {1'b0, 1'b1, 5'h1F, 1'b0, 5'd31, 5'd31, 5'd31, 10'd0};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  status_q, status_d;
  logic [15:0] retired_q, retired_d;
  logic        halted_q, halted_d;

  logic            mem_access;
  logic            commit;
  logic [CW_W-1:0] cw_stall;

  always_comb begin
    mem_access = cw_in[RAM_EN_BIT] | cw_in[RAM_W_BIT];
    commit     = ~mem_access | dmem_ready;
  end

  // A stalled word keeps the memory strobes alive but suppresses every
  // architectural side effect until the commit cycle.
  always_comb begin
    cw_stall                = cw_in;
    cw_stall[RF_W_BIT]      = 1'b0;
    cw_stall[PC_EN_BIT]     = 1'b0;
    cw_stall[STATUS_LD_BIT] = 1'b0;
  end

  always_comb begin
    fsm_d     = fsm_q;
    ir_d      = ir_q;
    state_d   = state_q;
    status_d  = status_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (fsm_q)
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          state_d = 2'd0;
          if (imem_data[31:26] == HALT_OP) begin
            fsm_d    = HALT;
            halted_d = 1'b1;
          end else begin
            fsm_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (commit) begin
          if (cw_in[STATUS_LD_BIT]) begin
            status_d = status_in;
          end
          state_d = cw_in[1:0];
          if (cw_in[1:0] == 2'd0) begin
            fsm_d     = FETCH;
            retired_d = retired_q + 16'd1;
          end
        end
      end
      HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        fsm_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q     <= FETCH;
      ir_q      <= 32'd0;
      state_q   <= 2'd0;
      status_q  <= 5'd0;
      retired_q <= 16'd0;
      halted_q  <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      ir_q      <= ir_d;
      state_q   <= state_d;
      status_q  <= status_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  // Datapath word is combinational so a stall or reset takes effect in-cycle.
  always_comb begin
    cw_out   = NOP_CW;
    imem_req = 1'b0;
    case (fsm_q)
      FETCH: imem_req = 1'b1;
      EXEC:  cw_out   = commit ? cw_in : cw_stall;
      default: begin
        cw_out   = NOP_CW;
        imem_req = 1'b0;
      end
    endcase
  end

  assign ir      = ir_q;
  assign state   = state_q;
  assign status  = status_q;
  assign retired = retired_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench for cpu_control_sequencer: per-cycle expectations are queued
// alongside the stimulus and compared against the DUT mid-cycle.
module tb_cpu_control_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [32:0] cw_in;
  logic        dmem_ready;
  logic [32:0] cw_out;
  logic [4:0]  status_in;
  logic [4:0]  status;
  logic        halted;
  logic [15:0] retired;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [32:0] cw;
    logic        chkReq;
    logic        req;
    logic [1:0]  st;
    logic [31:0] ir;
    logic [4:0]  status;
    logic [15:0] retired;
    logic        halted;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  cpu_control_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .ir         (ir),
    .state      (state),
    .cw_in      (cw_in),
    .dmem_ready (dmem_ready),
    .cw_out     (cw_out),
    .status_in  (status_in),
    .status     (status),
    .halted     (halted),
    .retired    (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] makeCw(
    input logic aluEn, input logic aluBs, input logic [4:0] aluFs,
    input logic rfBEn, input logic [4:0] sa, input logic [4:0] sb,
    input logic [4:0] da, input logic rfW, input logic ramEn,
    input logic ramW, input logic pcEn, input logic [1:0] pcFs,
    input logic pcIs, input logic statusLd, input logic [1:0] ns);
    return {aluEn, aluBs, aluFs, rfBEn, sa, sb, da, rfW, ramEn, ramW,
            pcEn, pcFs, pcIs, statusLd, ns};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] id, input logic iRdy,
                               input logic [32:0] cw, input logic dRdy,
                               input logic [4:0] si);
    imem_data  = id;
    imem_ready = iRdy;
    cw_in      = cw;
    dmem_ready = dRdy;
    status_in  = si;
  endtask

  task automatic expectCycle(input string tag, input logic [32:0] cw,
                             input logic chkReq, input logic req,
                             input logic [1:0] st, input logic [31:0] irv,
                             input logic [4:0] sts, input logic [15:0] ret,
                             input logic hlt);
    exp_t e;
    e.cw = cw; e.chkReq = chkReq; e.req = req; e.st = st; e.ir = irv;
    e.status = sts; e.retired = ret; e.halted = hlt;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic compareNext();
    exp_t  e;
    string t;
    if (expQ.size() == 0) begin
      checkOutput("sb_empty", 64'(expQ.size()), 64'd1);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, ".cw_out"}, 64'(cw_out), 64'(e.cw));
      if (e.chkReq) checkOutput({t, ".imem_req"}, 64'(imem_req), 64'(e.req));
      checkOutput({t, ".state"}, 64'(state), 64'(e.st));
      checkOutput({t, ".ir"}, 64'(ir), 64'(e.ir));
      checkOutput({t, ".status"}, 64'(status), 64'(e.status));
      checkOutput({t, ".retired"}, 64'(retired), 64'(e.retired));
      checkOutput({t, ".halted"}, 64'(halted), 64'(e.halted));
    end
  endtask

  task automatic stepCycle();
    @(negedge clock);
    compareNext();
    @(posedge clock);
    #1;
  endtask

  logic [32:0] nop, bl, alu1, alu2, ld, ldStall, st1, st1Stall, alu3, w4;

  initial begin
    nop      = makeCw(0, 1, 5'h1F, 0, 5'd31, 5'd31, 5'd31, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    bl       = makeCw(0, 0, 5'h00, 0, 5'd0, 5'd0, 5'd30, 1, 0, 0, 1, 2'b11, 1, 0, 2'b00);
    alu1     = makeCw(1, 0, 5'h02, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 0, 0, 2'b01);
    alu2     = makeCw(0, 0, 5'h00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'b01, 0, 0, 2'b00);
    ld       = makeCw(1, 0, 5'h02, 1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 1, 2'b00, 0, 0, 2'b00);
    ldStall  = makeCw(1, 0, 5'h02, 1, 5'd1, 5'd0, 5'd2, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00);
    st1      = makeCw(1, 0, 5'h05, 0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 2'b00, 0, 1, 2'b01);
    st1Stall = makeCw(1, 0, 5'h05, 0, 5'd1, 5'd2, 5'd0, 0, 1, 1, 0, 2'b00, 0, 0, 2'b01);
    alu3     = makeCw(1, 0, 5'h08, 0, 5'd4, 5'd5, 5'd6, 1, 0, 0, 0, 2'b00, 0, 0, 2'b10);
    w4       = makeCw(1, 0, 5'h01, 0, 5'd7, 5'd8, 5'd9, 1, 0, 0, 1, 2'b00, 0, 1, 2'b00);

    reset = 1'b1;
    applyStimulus(32'd0, 0, 33'd0, 0, 5'd0);
    #3;
    expectCycle("por", nop, 0, 0, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    compareNext();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // BL: one execute state, then back to fetch with retired=1
    applyStimulus(32'h94000010, 1, 33'd0, 0, 5'd0);
    expectCycle("bl_fetch", nop, 1, 1, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    stepCycle();
    applyStimulus(32'h0, 0, bl, 0, 5'd0);
    expectCycle("bl_exec", bl, 1, 0, 2'd0, 32'h94000010, 5'd0, 16'd0, 0);
    stepCycle();
    applyStimulus(32'h12345678, 0, bl, 0, 5'd0);
    expectCycle("fetch_wait", nop, 1, 1, 2'd0, 32'h94000010, 5'd0, 16'd1, 0);
    stepCycle();

    // Two-state instruction: states 0 then 1
    applyStimulus(32'h00400001, 1, 33'd0, 0, 5'd0);
    expectCycle("two_fetch", nop, 1, 1, 2'd0, 32'h94000010, 5'd0, 16'd1, 0);
    stepCycle();
    applyStimulus(32'h0, 0, alu1, 0, 5'd3);
    expectCycle("two_s0", alu1, 1, 0, 2'd0, 32'h00400001, 5'd0, 16'd1, 0);
    stepCycle();
    applyStimulus(32'h0, 0, alu2, 0, 5'd3);
    expectCycle("two_s1", alu2, 1, 0, 2'd1, 32'h00400001, 5'd0, 16'd1, 0);
    stepCycle();

    // Load with three wait cycles
    applyStimulus(32'h8C220004, 1, 33'd0, 0, 5'd0);
    expectCycle("ld_fetch", nop, 1, 1, 2'd0, 32'h00400001, 5'd0, 16'd2, 0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 1, ld, 0, 5'h1F);
      expectCycle($sformatf("ld_stall%0d", i), ldStall, 1, 0, 2'd0,
                  32'h8C220004, 5'd0, 16'd2, 0);
      stepCycle();
    end
    applyStimulus(32'h0, 1, ld, 1, 5'h1F);
    expectCycle("ld_commit", ld, 1, 0, 2'd0, 32'h8C220004, 5'd0, 16'd2, 0);
    stepCycle();

    // Status load on a stalled store, then a non-loading state
    applyStimulus(32'h00221820, 1, 33'd0, 0, 5'd0);
    expectCycle("sts_fetch", nop, 1, 1, 2'd0, 32'h8C220004, 5'd0, 16'd3, 0);
    stepCycle();
    applyStimulus(32'h0, 0, st1, 0, 5'b10110);
    expectCycle("sts_stall", st1Stall, 1, 0, 2'd0, 32'h00221820, 5'd0, 16'd3, 0);
    stepCycle();
    applyStimulus(32'h0, 0, st1, 1, 5'b10110);
    expectCycle("sts_commit", st1, 1, 0, 2'd0, 32'h00221820, 5'd0, 16'd3, 0);
    stepCycle();
    applyStimulus(32'h0, 0, alu3, 0, 5'b00001);
    expectCycle("sts_hold", alu3, 1, 0, 2'd1, 32'h00221820, 5'b10110, 16'd3, 0);
    stepCycle();

    // Async reset in the middle of execute state 2
    applyStimulus(32'h0, 0, w4, 0, 5'b01010);
    expectCycle("mid_s2", w4, 1, 0, 2'd2, 32'h00221820, 5'b10110, 16'd3, 0);
    @(negedge clock);
    compareNext();
    #2;
    reset = 1'b1;
    #1;
    expectCycle("async_rst", nop, 0, 0, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    compareNext();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // HALT opcode parks the sequencer until reset
    applyStimulus(32'hFC000000, 1, 33'd0, 0, 5'd0);
    expectCycle("halt_fetch", nop, 1, 1, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h94000010, 1, bl, 1, 5'h1F);
      expectCycle($sformatf("halt%0d", i), nop, 1, 0, 2'd0, 32'hFC000000,
                  5'd0, 16'd0, 1);
      stepCycle();
    end
    #2;
    reset = 1'b1;
    #1;
    expectCycle("halt_rst", nop, 0, 0, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    compareNext();
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(32'h0, 0, bl, 0, 5'd0);
    expectCycle("post_halt", nop, 1, 1, 2'd0, 32'd0, 5'd0, 16'd0, 0);
    stepCycle();

    checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Multi-cycle control sequencer for the CPU datapath. It fetches each instruction into the instruction register and presents the IR and the 2-bit execute state to the combinational decoder bank (BL, branch, ALU, load/store decoders). It takes back the selected 33-bit control word and steps through the execute states using the word's next_state field. Memory accesses stall on a ready handshake, and the status register is kept here.

Parameters:
HALT_OP, 6'h3F, opcode (IR[31:26]) that parks the sequencer in HALT
CW_W, 33, control word width (field layout below, fixed)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
imem_data  in  32  instruction word from instruction memory
imem_ready  in  1  imem_data valid this cycle
imem_req  out  1  instruction fetch request
ir  out  32  instruction register, to decoder bank
state  out  2  current execute state, to decoder bank
cw_in  in  33  control word from decoder bank for (ir, state)
dmem_ready  in  1  data RAM access complete this cycle
cw_out  out  33  control word driven to datapath
status_in  in  5  ALU status flags
status  out  5  status register, to decoder bank
halted  out  1  sequencer in HALT
retired  out  16  retired-instruction counter

Behaviour:
- Control word layout, MSB first:
  - [32] alu_en; [31] alu_bs; [30:26] alu_fs; [25] rf_b_en
  - [24:20] rf_sa; [19:15] rf_sb; [14:10] rf_da
  - [9] rf_w; [8] ram_en; [7] ram_w; [6] pc_en
  - [5:4] pc_fs; [3] pc_is; [2] status_ld; [1:0] next_state
- NOP word: alu_bs=1, alu_fs=5'b11111, rf_sa=rf_sb=rf_da=31; every other bit 0.
- FSM has three states: FETCH, EXEC, HALT.
- Reset (async, any time, including mid-EXEC or mid-stall):
  - FSM=FETCH, state=0, ir=0, status=0, retired=0, halted=0.
  - cw_out=NOP, imem_req=1 once reset deasserts.
- FETCH:
  - imem_req=1, cw_out=NOP.
  - If imem_ready: ir<=imem_data, state<=0.
  - Next FSM is HALT if imem_data[31:26]==HALT_OP, else EXEC.
  - If imem_ready=0: hold FETCH, ir unchanged.
- EXEC:
  - imem_req=0.
  - mem = cw_in[8] | cw_in[7]; commit = ~mem | dmem_ready.
  - commit=1: cw_out=cw_in, unchanged.
    - status<=status_in if cw_in[2].
    - state<=cw_in[1:0].
    - If cw_in[1:0]==0: FSM<=FETCH and retired<=retired+1 (wraps 16'hFFFF->0). Otherwise stay in EXEC.
  - commit=0 (stall): cw_out=cw_in with rf_w, pc_en, status_ld forced 0; ram_en/ram_w held.
    - state, status, ir held; no PC or register side effects until the commit cycle.
- HALT:
  - cw_out=NOP, imem_req=0, halted=1.
  - Exit only by reset; imem_ready and dmem_ready are ignored.
- Latency:
  - Fetch takes at least 1 cycle.
  - Each execute state takes 1 cycle plus stall cycles.
  - Single-state instruction with 0-wait memory: 2 cycles per instruction.
- cw_out and imem_req are combinational from FSM, cw_in and dmem_ready. ir, state, status, retired and halted are registered.
- cw_in is ignored outside EXEC.
- next_state values 1..3 are followed exactly as returned; the decoder bank owns termination.

Test Plan:
- Reset pulse mid-cycle (async) during EXEC state 2 -> same-cycle cw_out=NOP, state=0, ir=0, retired=0; after release imem_req=1.
- Fetch 32'h94000010 with imem_ready=1; decoder returns BL word (pc_en=1, pc_fs=11, pc_is=1, rf_w=1, rf_da=30, next_state=00) -> cw_out equals it for 1 cycle; next cycle FETCH; retired=1.
- Two-state instruction: cw_in next_state=01 then 00 -> state sequence 0,1,0; exactly 2 EXEC cycles; retired increments once.
- Load word (ram_en=1, rf_w=1) with dmem_ready low 3 cycles -> rf_w=0, pc_en=0 for 3 cycles with ram_en=1; on the 4th cycle rf_w=1 and FETCH follows.
- ALU word with status_ld=1, status_in=5'b10110 -> status=5'b10110 after commit; during stall or status_ld=0 cycles status unchanged.
- Fetch 32'hFC000000 -> halted=1, cw_out=NOP, imem_req=0 indefinitely; retired unchanged; reset clears halted.
